jtbubl_vtiming: RTL and testbench

JTBUBL_VTIMING -- requirements
Module: jtbubl_vtiming

---
 rtl/jtbubl_vtiming_pkg.sv | 26 ++
 rtl/jtbubl_vtiming_cen.sv | 35 +++
 rtl/jtbubl_vtiming.sv | 138 +++++++++++++
 tb/tb_jtbubl_vtiming.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/jtbubl_vtiming_pkg.sv
// Default video timing constants shared by the vertical timing block and the video top.
// Also holds the inclusive, possibly wrapping, window test used by all blank/sync decodes.
package jtbubl_vtiming_pkg;

   localparam int unsigned DEF_CLK_DIV  = 8;
   localparam int unsigned DEF_W        = 9;
   localparam int unsigned DEF_HTOTAL   = 384;
   localparam int unsigned DEF_VTOTAL   = 264;
   localparam int unsigned DEF_HB_START = 255;
   localparam int unsigned DEF_HB_END   = 383;
   localparam int unsigned DEF_HS_START = 287;
   localparam int unsigned DEF_HS_END   = 319;
   localparam int unsigned DEF_VB_START = 223;
   localparam int unsigned DEF_VB_END   = 263;
   localparam int unsigned DEF_VS_START = 232;
   localparam int unsigned DEF_VS_END   = 235;
   localparam int unsigned DEF_DLY      = 2;

   // START > END means the window wraps through zero
   function automatic logic in_win(input int unsigned val, input int unsigned win_start,
                                   input int unsigned win_end);
      if (win_start <= win_end) return (val >= win_start) && (val <= win_end);
      else                      return (val >= win_start) || (val <= win_end);
   endfunction

endpackage

// File: rtl/jtbubl_vtiming_cen.sv
// Pixel clock-enable divider: pxl_cen once per CLK_DIV clocks, pxl2_cen twice.
// Enables are registered so they are cleanly low during reset for any CLK_DIV.
module jtbubl_vtiming_cen
   import jtbubl_vtiming_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic pxl_cen,
   output logic pxl2_cen
);

   localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         pxl_cen  <= 1'b0;
         pxl2_cen <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         pxl_cen  <= (cnt_nxt == CW'(CLK_DIV - 1));
         pxl2_cen <= (cnt_nxt == CW'(CLK_DIV / 2 - 1)) || (cnt_nxt == CW'(CLK_DIV - 1));
      end
   end

endmodule

// File: rtl/jtbubl_vtiming.sv
// Video timing generator: H/V counters, blank/sync windows, delayed blanks and strobes.
// Optional screen flip is enabled by defining JTBUBL_VTIMING_FLIP_EN.
module jtbubl_vtiming
   import jtbubl_vtiming_pkg::*;
#(
   parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
   parameter int unsigned W        = DEF_W,
   parameter int unsigned HTOTAL   = DEF_HTOTAL,
   parameter int unsigned VTOTAL   = DEF_VTOTAL,
   parameter int unsigned HB_START = DEF_HB_START,
   parameter int unsigned HB_END   = DEF_HB_END,
   parameter int unsigned HS_START = DEF_HS_START,
   parameter int unsigned HS_END   = DEF_HS_END,
   parameter int unsigned VB_START = DEF_VB_START,
   parameter int unsigned VB_END   = DEF_VB_END,
   parameter int unsigned VS_START = DEF_VS_START,
   parameter int unsigned VS_END   = DEF_VS_END,
   parameter int unsigned DLY      = DEF_DLY
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flip_in,
   output logic         pxl2_cen,
   output logic         pxl_cen,
   output logic [W-1:0] hdump,
   output logic [W-1:0] vdump,
   output logic [W-1:0] vrender,
   output logic [W-1:0] vrender1,
   output logic         Hinit,
   output logic         Vinit,
   output logic         LHBL,
   output logic         LVBL,
   output logic         LHBL_dly,
   output logic         LVBL_dly,
   output logic         HS,
   output logic         VS,
   output logic         flip
);

   logic [W-1:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
   logic [W-1:0] vr, vr1, fmask;
   logic         hwrap;

   jtbubl_vtiming_cen #(
      .CLK_DIV (CLK_DIV)
   ) u_cen (
      .clk      (clk),
      .rst_n    (rst_n),
      .pxl_cen  (pxl_cen),
      .pxl2_cen (pxl2_cen)
   );

   assign hwrap = (hcnt == W'(HTOTAL - 1));
   assign Hinit = pxl_cen && hwrap;
   assign Vinit = Hinit && (vcnt == W'(VTOTAL - 1));

   always_comb begin
      hcnt_nxt = hwrap ? '0 : hcnt + W'(1);
      vcnt_nxt = vcnt;
      if (hwrap) vcnt_nxt = (vcnt == W'(VTOTAL - 1)) ? '0 : vcnt + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt <= '0;
         vcnt <= '0;
         LHBL <= 1'b0;
         LVBL <= 1'b0;
         HS   <= 1'b0;
         VS   <= 1'b0;
      end else if (pxl_cen) begin
         hcnt <= hcnt_nxt;
         vcnt <= vcnt_nxt;
         LHBL <= ~in_win(32'(hcnt_nxt), HB_START, HB_END);
         LVBL <= ~in_win(32'(vcnt_nxt), VB_START, VB_END);
         HS   <= in_win(32'(hcnt_nxt), HS_START, HS_END);
         VS   <= in_win(32'(vcnt_nxt), VS_START, VS_END);
      end
   end

   generate
      if (DLY == 0) begin : g_nodly
         assign LHBL_dly = LHBL;
         assign LVBL_dly = LVBL;
      end else begin : g_dly
         logic [DLY-1:0] hb_sr, vb_sr;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hb_sr <= '0;
               vb_sr <= '0;
            end else if (pxl_cen) begin
               hb_sr[0] <= LHBL;
               vb_sr[0] <= LVBL;
               for (int i = 1; i < int'(DLY); i++) begin
                  hb_sr[i] <= hb_sr[i-1];
                  vb_sr[i] <= vb_sr[i-1];
               end
            end
         end
         assign LHBL_dly = hb_sr[DLY-1];
         assign LVBL_dly = vb_sr[DLY-1];
      end
   endgenerate

   // Render lines are forced low in reset so every output reads zero there
   always_comb begin
      vr  = (vcnt == W'(VTOTAL - 1)) ? '0 : vcnt + W'(1);
      vr1 = (vcnt >= W'(VTOTAL - 2)) ? vcnt - W'(VTOTAL - 2) : vcnt + W'(2);
      if (!rst_n) begin
         vr  = '0;
         vr1 = '0;
      end
   end

`ifdef JTBUBL_VTIMING_FLIP_EN
   logic flip_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     flip_q <= 1'b0;
      else if (Vinit) flip_q <= flip_in;
   end

   assign flip  = flip_q;
   assign fmask = {W{flip_q}};
`else
   logic unused_flip_in;

   assign unused_flip_in = flip_in;
   assign flip           = 1'b0;
   assign fmask          = '0;
`endif

   assign hdump    = hcnt ^ fmask;
   assign vdump    = vcnt ^ fmask;
   assign vrender  = vr ^ fmask;
   assign vrender1 = vr1 ^ fmask;

endmodule

// File: tb/tb_jtbubl_vtiming.sv
// Self-checking bench: derives every output from the clock count since reset release.
// Flip behaviour is modelled only when JTBUBL_VTIMING_FLIP_EN is defined.
module tb_jtbubl_vtiming;

   localparam int CD   = 4;
   localparam int WW   = 9;
   localparam int HT   = 48;
   localparam int VT   = 20;
   localparam int HBS  = 44;
   localparam int HBE  = 3;
   localparam int HSS  = 20;
   localparam int HSE  = 25;
   localparam int VBS  = 16;
   localparam int VBE  = 19;
   localparam int VSS  = 19;
   localparam int VSE  = 1;
   localparam int DL   = 2;
   localparam int MASK = (1 << WW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flip_in = 1'b0;
   logic          pxl2_cen, pxl_cen, Hinit, Vinit;
   logic          LHBL, LVBL, LHBL_dly, LVBL_dly, HS, VS, flip;
   logic [WW-1:0] hdump, vdump, vrender, vrender1;

   int n_assert = 0;
   int n_fail   = 0;
   int edges    = 0;
   bit flip_m   = 1'b0;

   jtbubl_vtiming #(
      .CLK_DIV (CD), .W (WW), .HTOTAL (HT), .VTOTAL (VT),
      .HB_START (HBS), .HB_END (HBE), .HS_START (HSS), .HS_END (HSE),
      .VB_START (VBS), .VB_END (VBE), .VS_START (VSS), .VS_END (VSE),
      .DLY (DL)
   ) dut (
      .clk (clk), .rst_n (rst_n), .flip_in (flip_in),
      .pxl2_cen (pxl2_cen), .pxl_cen (pxl_cen),
      .hdump (hdump), .vdump (vdump), .vrender (vrender), .vrender1 (vrender1),
      .Hinit (Hinit), .Vinit (Vinit), .LHBL (LHBL), .LVBL (LVBL),
      .LHBL_dly (LHBL_dly), .LVBL_dly (LVBL_dly), .HS (HS), .VS (VS), .flip (flip)
   );

   always #5 clk = ~clk;

   function automatic bit win(input int x, input int s, input int e);
      return (s <= e) ? (x >= s && x <= e) : (x >= s || x <= e);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (t=%0t edge=%0d)", tag, obs, exp, $time,
                edges);
      end
   endtask

   task automatic check_zero();
      chk("rst_pxl_cen", 32'(pxl_cen), 0);   chk("rst_pxl2_cen", 32'(pxl2_cen), 0);
      chk("rst_hdump", 32'(hdump), 0);       chk("rst_vdump", 32'(vdump), 0);
      chk("rst_vrender", 32'(vrender), 0);   chk("rst_vrender1", 32'(vrender1), 0);
      chk("rst_Hinit", 32'(Hinit), 0);       chk("rst_Vinit", 32'(Vinit), 0);
      chk("rst_LHBL", 32'(LHBL), 0);         chk("rst_LVBL", 32'(LVBL), 0);
      chk("rst_LHBL_dly", 32'(LHBL_dly), 0); chk("rst_LVBL_dly", 32'(LVBL_dly), 0);
      chk("rst_HS", 32'(HS), 0);             chk("rst_VS", 32'(VS), 0);
      chk("rst_flip", 32'(flip), 0);
   endtask

   // Pixel ticks land on edges CD, 2*CD, ...; counters equal ticks modulo the totals.
   task automatic check_run();
      int p, h, v, q, qh, qv, fm;
      bit cen, cen2, hi;
      p    = edges / CD;
      h    = p % HT;
      v    = (p / HT) % VT;
      cen  = (edges % CD) == CD - 1;
      cen2 = (edges % (CD / 2)) == CD / 2 - 1;
      hi   = cen && (h == HT - 1);
`ifdef JTBUBL_VTIMING_FLIP_EN
      if (p > 0 && (edges % CD) == 0 && (p % (HT * VT)) == 0) flip_m = flip_in;
`endif
      fm = flip_m ? MASK : 0;
      chk("pxl_cen", 32'(pxl_cen), 32'(cen));
      chk("pxl2_cen", 32'(pxl2_cen), 32'(cen2));
      chk("hdump", 32'(hdump), 32'(h ^ fm));
      chk("vdump", 32'(vdump), 32'(v ^ fm));
      chk("vrender", 32'(vrender), 32'(((v + 1) % VT) ^ fm));
      chk("vrender1", 32'(vrender1), 32'(((v + 2) % VT) ^ fm));
      chk("Hinit", 32'(Hinit), 32'(hi));
      chk("Vinit", 32'(Vinit), 32'(hi && (v == VT - 1)));
      chk("LHBL", 32'(LHBL), 32'(p >= 1 && !win(h, HBS, HBE)));
      chk("LVBL", 32'(LVBL), 32'(p >= 1 && !win(v, VBS, VBE)));
      chk("HS", 32'(HS), 32'(p >= 1 && win(h, HSS, HSE)));
      chk("VS", 32'(VS), 32'(p >= 1 && win(v, VSS, VSE)));
      q  = p - DL;
      qh = (q >= 1) ? q % HT : 0;
      qv = (q >= 1) ? (q / HT) % VT : 0;
      chk("LHBL_dly", 32'(LHBL_dly), 32'(q >= 1 && !win(qh, HBS, HBE)));
      chk("LVBL_dly", 32'(LVBL_dly), 32'(q >= 1 && !win(qv, VBS, VBE)));
      chk("flip", 32'(flip), 32'(flip_m));
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         edges++;
         check_run();
         if ($urandom_range(0, 299) == 0) flip_in = ~flip_in;
      end
   endtask

   // Reset is asserted and released between clock edges, mid-frame.
   task automatic do_reset(input int len);
      #2 rst_n = 1'b0;
      #1 check_zero();
      flip_m = 1'b0;
      repeat (len) begin
         @(posedge clk);
         #1 check_zero();
      end
      #2 rst_n = 1'b1;
      edges = 0;
   endtask

   initial begin
      repeat (3) begin
         @(posedge clk);
         #1 check_zero();
      end
      #2 rst_n = 1'b1;
      edges = 0;
      step(2 * HT * VT * CD + 100);
      step($urandom_range(100, 2000));
      do_reset($urandom_range(1, 4));
      step(HT * VT * CD + 50);
      step($urandom_range(50, 1500));
      do_reset(2);
      step(600);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
